dram_mc: RTL and testbench

- Parametrised successor to the 8-channel behavioural DRAM model. Several requester channels share one single-port storage array.
- Adds a per-channel request/accept handshake, round-robin arbitration, per-channel read/write select, a programmable access latency and out-of-range error reporting.
- Sits below the parser/decoder engines as the memory model for simulation and integration benches.

---
 rtl/dram_pkg.sv | 20 ++
 rtl/dram_mc_rr_arbiter.sv | 31 +++
 rtl/dram_mc.sv | 109 ++++++++++
 tb/tb_dram_mc.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types and sizing helpers for the multi-channel DRAM model.
// No logic; imported by dram_mc and rr_arbiter.
// No flow control of its own.
package dram_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic RDWR_WRITE = 1'b0;
  localparam logic RDWR_READ  = 1'b1;

  // Counter only ever holds LATENCY-1, so LATENCY=1 still needs one bit.
  function automatic int cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dram_mc_rr_arbiter.sv
// Round-robin pick of the first set req at or after ptr, wrapping.
// Purely combinational, zero latency.
// No backpressure; caller decides when the grant is consumed.
module rr_arbiter
  import dram_pkg::*;
#(
  parameter int NUM_CH = 8
) (
  input  logic [NUM_CH-1:0]       req,
  input  logic [ch_w(NUM_CH)-1:0] ptr,
  output logic [ch_w(NUM_CH)-1:0] grant,
  output logic                    any_req
);

  localparam int CHW = ch_w(NUM_CH);

  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = CHW'(idx);
      end
    end
  end

endmodule

// File: rtl/dram_mc.sv
// Shared single-port DRAM model serving NUM_CH requesters, one request in flight.
// Latency: valid LATENCY edges after the accept edge; one request per LATENCY+1 cycles.
// Backpressure: a request waits (en held) until its one-cycle ready pulse.
module dram_mc
  import dram_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              en,
  input  logic [NUM_CH-1:0]              rdwr,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  data_in,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  addr,
  output logic [NUM_CH-1:0]              ready,
  output logic [NUM_CH-1:0][DATA_W-1:0]  data_out,
  output logic [NUM_CH-1:0]              valid,
  output logic [NUM_CH-1:0]              err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CHW = ch_w(NUM_CH);
  localparam int CW  = cnt_w(LATENCY);

  state_t            state;
  logic [CHW-1:0]    ptr;
  logic [CHW-1:0]    g;
  logic [CHW-1:0]    next_ptr;
  logic [CHW-1:0]    arb_ptr;
  logic [CHW-1:0]    grant;
  logic              any_req;
  logic              op;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [CW-1:0]     cnt;
  logic              oor;
  logic [DATA_W-1:0] mem [DEPTH];

  assign next_ptr = (g == CHW'(NUM_CH - 1)) ? '0 : g + 1'b1;
  // RESP doubles as an accept slot, arbitrating from the already-advanced pointer.
  assign arb_ptr  = (state == RESP) ? next_ptr : ptr;
  assign oor      = (lat_addr >> AW) != '0;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (en),
    .ptr     (arb_ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      g        <= '0;
      cnt      <= '0;
      op       <= RDWR_WRITE;
      lat_addr <= '0;
      lat_data <= '0;
      ready    <= '0;
      valid    <= '0;
      err      <= '0;
      data_out <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ready <= '0;
      valid <= '0;
      err   <= '0;
      case (state)
        IDLE, RESP: begin
          if (state == RESP) ptr <= next_ptr;
          if (any_req) begin
            g            <= grant;
            op           <= rdwr[grant];
            lat_addr     <= addr[grant];
            lat_data     <= data_in[grant];
            cnt          <= CW'(LATENCY - 1);
            ready[grant] <= 1'b1;
            state        <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state    <= RESP;
            valid[g] <= 1'b1;
            if (oor) begin
              err[g] <= 1'b1;
            end else if (op == RDWR_WRITE) begin
              mem[lat_addr[AW-1:0]] <= lat_data;
              data_out[g]           <= lat_data;
            end else begin
              data_out[g] <= mem[lat_addr[AW-1:0]];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_mc.sv
// Directed bench for dram_mc: default 8-channel instance plus a 2-channel LATENCY=1 instance.
`timescale 1ns/1ps
module tb_dram_mc;
  import dram_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]        en, rdwr, ready, valid, err;
  logic [N-1:0][7:0]   data_in, data_out;
  logic [N-1:0][63:0]  addr;
  logic [1:0]          s_en, s_rdwr, s_ready, s_valid, s_err;
  logic [1:0][31:0]    s_din, s_dout;
  logic [1:0][63:0]    s_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dram_mc u_dut (
    .clk(clk), .reset(reset), .en(en), .rdwr(rdwr), .data_in(data_in), .addr(addr),
    .ready(ready), .data_out(data_out), .valid(valid), .err(err)
  );

  dram_mc #(.NUM_CH(2), .DATA_W(32), .LATENCY(1)) u_small (
    .clk(clk), .reset(reset), .en(s_en), .rdwr(s_rdwr), .data_in(s_din), .addr(s_addr),
    .ready(s_ready), .data_out(s_dout), .valid(s_valid), .err(s_err)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Single request on the 8-channel DUT; reports latencies and sampled outputs.
  task automatic do_req(input int ch, input logic rd, input logic [63:0] a, input logic [7:0] d,
                        output int rlat, output int vlat, output logic e, output logic [7:0] q,
                        output logic rdy2, output logic vld2, output logic [7:0] q2);
    en[ch] = 1'b1; rdwr[ch] = rd; addr[ch] = a; data_in[ch] = d;
    rlat = -1; vlat = -1; e = 1'bx; q = 'x; rdy2 = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ready[ch]) begin rlat = n; break; end
    end
    en[ch] = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) rdy2 = ready[ch];
      if (valid[ch]) begin vlat = n; e = err[ch]; q = data_out[ch]; break; end
    end
    @(posedge clk); #1;
    vld2 = valid[ch];
    q2   = data_out[ch];
  endtask

  int          g_ch[$];
  int          g_t[$];
  int          vcnt[N];
  logic [7:0]  vdat[N];
  logic        verr[N];

  // Raise en on mask, drop each non-sticky channel at its ready, log grants and responses.
  task automatic serve(input logic [N-1:0] mask, input logic [N-1:0] sticky,
                       input int max_g, input int budget);
    g_ch.delete(); g_t.delete();
    for (int i = 0; i < N; i++) begin vcnt[i] = 0; vdat[i] = '0; verr[i] = 1'b0; end
    en = mask;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (ready != '0) begin
        chk("ready_onehot", 64'($countones(ready)), 64'd1);
        for (int i = 0; i < N; i++) begin
          if (ready[i]) begin
            g_ch.push_back(i); g_t.push_back(n);
            if (!sticky[i]) en[i] = 1'b0;
          end
        end
        if (g_ch.size() >= max_g) en = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (valid[i]) begin vcnt[i]++; vdat[i] = data_out[i]; verr[i] = verr[i] | err[i]; end
      end
    end
    en = '0;
  endtask

  task automatic do_req_s(input int ch, input logic rd, input logic [63:0] a, input logic [31:0] d,
                          input logic [31:0] exp_q, input string name);
    int rlat, vlat;
    logic [31:0] q;
    s_en[ch] = 1'b1; s_rdwr[ch] = rd; s_addr[ch] = a; s_din[ch] = d;
    rlat = -1; vlat = -1; q = 'x;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (s_ready[ch]) begin rlat = n; break; end
    end
    s_en[ch] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (s_valid[ch]) begin vlat = n; q = s_dout[ch]; break; end
    end
    chk({name, "_rlat"}, 64'(rlat), 64'd1);
    chk({name, "_vlat"}, 64'(vlat), 64'd1);
    chk({name, "_data"}, 64'(q), 64'(exp_q));
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          ch;
    logic        rd;
    logic [63:0] a;
    logic [7:0]  d;
    logic        e;
    logic [7:0]  q;
  } vec_t;

  vec_t vt[11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rlat, vlat;
    logic e, rdy2, vld2, seen_v;
    logic [7:0] q, q2;
    int s_ch[$];
    int s_t[$];

    vt[0]  = '{0, RDWR_WRITE, 64'h0,                  8'h01, 1'b0, 8'h01};
    vt[1]  = '{0, RDWR_READ,  64'h0,                  8'h00, 1'b0, 8'h01};
    vt[2]  = '{2, RDWR_WRITE, 64'hFF,                 8'h5A, 1'b0, 8'h5A};
    vt[3]  = '{2, RDWR_READ,  64'hFF,                 8'h00, 1'b0, 8'h5A};
    vt[4]  = '{7, RDWR_WRITE, 64'h10,                 8'hC3, 1'b0, 8'hC3};
    vt[5]  = '{5, RDWR_READ,  64'h10,                 8'h00, 1'b0, 8'hC3};
    vt[6]  = '{3, RDWR_READ,  64'h100,                8'h00, 1'b1, 8'h00};
    vt[7]  = '{4, RDWR_READ,  64'h0,                  8'h00, 1'b0, 8'h01};
    vt[8]  = '{6, RDWR_WRITE, 64'h8000_0000_0000_0000, 8'h77, 1'b1, 8'h00};
    vt[9]  = '{6, RDWR_READ,  64'h0,                  8'h00, 1'b0, 8'h01};
    vt[10] = '{1, RDWR_READ,  64'h33,                 8'h00, 1'b0, 8'h00};

    en = '0; rdwr = '0; data_in = '0; addr = '0;
    s_en = '0; s_rdwr = '0; s_din = '0; s_addr = '0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready",    64'(ready),    64'd0);
    chk("rst_valid",    64'(valid),    64'd0);
    chk("rst_err",      64'(err),      64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_s_out",    64'({s_ready, s_valid, s_err}), 64'd0);
    chk("rst_s_dout",   64'(s_dout),   64'd0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_req(vt[i].ch, vt[i].rd, vt[i].a, vt[i].d, rlat, vlat, e, q, rdy2, vld2, q2);
      chk($sformatf("v%0d_ready_lat", i), 64'(rlat), 64'd1);
      chk($sformatf("v%0d_valid_lat", i), 64'(vlat), 64'd10);
      chk($sformatf("v%0d_ready_1cyc", i), 64'(rdy2), 64'd0);
      chk($sformatf("v%0d_valid_1cyc", i), 64'(vld2), 64'd0);
      chk($sformatf("v%0d_err", i), 64'(e), 64'(vt[i].e));
      chk($sformatf("v%0d_data", i), 64'(q), 64'(vt[i].q));
      chk($sformatf("v%0d_hold", i), 64'(q2), 64'(vt[i].q));
    end

    // Round robin: all eight write i+0x10 to addr i, then read a rotated address.
    do_reset();
    rdwr = '0;
    for (int i = 0; i < N; i++) begin addr[i] = 64'(i); data_in[i] = 8'(8'h10 + i); end
    serve(8'hFF, 8'h00, 8, 110);
    chk("rr_wr_count", 64'(g_ch.size()), 64'd8);
    for (int k = 0; k < g_ch.size(); k++) begin
      chk($sformatf("rr_wr_order%0d", k), 64'(g_ch[k]), 64'(k));
      if (k > 0) chk($sformatf("rr_wr_gap%0d", k), 64'(g_t[k] - g_t[k-1]), 64'd11);
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rr_wr_vcnt%0d", i), 64'(vcnt[i]), 64'd1);
      chk($sformatf("rr_wr_data%0d", i), 64'(vdat[i]), 64'(8'h10 + i));
    end
    rdwr = '1;
    for (int i = 0; i < N; i++) addr[i] = 64'((i + 1) % N);
    serve(8'hFF, 8'h00, 8, 110);
    chk("rr_rd_count", 64'(g_ch.size()), 64'd8);
    for (int k = 0; k < g_ch.size(); k++)
      chk($sformatf("rr_rd_order%0d", k), 64'(g_ch[k]), 64'(k));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rr_rd_data%0d", i), 64'(vdat[i]), 64'(8'h10 + ((i + 1) % N)));
      chk($sformatf("rr_rd_err%0d", i), 64'(verr[i]), 64'd0);
    end

    // Fairness across the wrap: serving ch5 leaves the pointer at 6.
    do_req(5, RDWR_READ, 64'h0, 8'h00, rlat, vlat, e, q, rdy2, vld2, q2);
    chk("fair_pre_data", 64'(q), 64'h10);
    addr[6] = 64'h1; addr[0] = 64'h2;
    serve(8'h41, 8'h40, 3, 50);
    chk("fair_count", 64'(g_ch.size()), 64'd3);
    if (g_ch.size() == 3) begin
      chk("fair_g0", 64'(g_ch[0]), 64'd6);
      chk("fair_g1", 64'(g_ch[1]), 64'd0);
      chk("fair_g2", 64'(g_ch[2]), 64'd6);
      chk("fair_gap", 64'(g_t[2] - g_t[0]), 64'd22);
    end
    chk("fair_vcnt6", 64'(vcnt[6]), 64'd2);
    chk("fair_data0", 64'(vdat[0]), 64'h12);

    // Reset four cycles into a write: no response, no write.
    do_reset();
    en[1] = 1'b1; rdwr[1] = RDWR_WRITE; addr[1] = 64'h5; data_in[1] = 8'hAA;
    rlat = -1; seen_v = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (ready[1]) begin rlat = n; break; end
    end
    en[1] = 1'b0;
    chk("abort_accept", 64'(rlat), 64'd1);
    repeat (4) begin @(posedge clk); #1; seen_v = seen_v | valid[1]; end
    reset = 1'b0;
    #1;
    chk("abort_outs", 64'({ready, valid, err}), 64'd0);
    repeat (3) begin @(posedge clk); #1; seen_v = seen_v | valid[1]; end
    reset = 1'b1;
    do_req(1, RDWR_READ, 64'h5, 8'h00, rlat, vlat, e, q, rdy2, vld2, q2);
    chk("abort_no_valid", 64'(seen_v), 64'd0);
    chk("abort_rd_vlat", 64'(vlat), 64'd10);
    chk("abort_rd_data", 64'(q), 64'h00);

    // Two-channel, 32-bit, LATENCY=1 instance.
    do_reset();
    do_req_s(0, RDWR_WRITE, 64'h3, 32'hDEADBEEF, 32'hDEADBEEF, "s_wr");
    do_req_s(1, RDWR_READ,  64'h3, 32'h0,        32'hDEADBEEF, "s_rd");
    s_rdwr = 2'b11; s_addr[0] = 64'h3; s_addr[1] = 64'h3;
    s_en = 2'b11;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) if (s_ready[i]) begin s_ch.push_back(i); s_t.push_back(n); end
      if (s_ch.size() >= 4) s_en = '0;
    end
    s_en = '0;
    chk("s_b2b_count", 64'(s_ch.size()), 64'd4);
    for (int k = 0; k < s_ch.size(); k++) begin
      chk($sformatf("s_b2b_order%0d", k), 64'(s_ch[k]), 64'(k % 2));
      if (k > 0) chk($sformatf("s_b2b_gap%0d", k), 64'(s_t[k] - s_t[k-1]), 64'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
